dpb_stream_reader: RTL and testbench
====================================

# dpb_stream_reader

Port-B read engine for the Gowin dual-port block RAM: on a start command it reads `length` consecutive bytes beginning at `base_addr` and presents them as a valid/ready byte stream. It sits on the read side of the DPB while a producer writes through port A. The block hides the RAM read latency behind a 4-entry prefetch FIFO and is credit-limited so no read result is ever dropped under backpressure.

## Interface
Parameters:
- `ADDR_W`, default 14: RAM address width; wraps modulo 2^ADDR_W.
- `DATA_W`, default 8: RAM and stream data width.
- `RD_LAT`, default 2: RAM read latency in clocks. Legal values are 1 (bypass mode) and 2 (output register enabled).

Ports:
- `clk`  in  1  single clock for the block and RAM port B.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only while idle.
- `base_addr`  in  ADDR_W  first read address; captured with `start`.
- `length`  in  ADDR_W+1  byte count, 0..2^ADDR_W; captured with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the command completes.
- `adb`  out  ADDR_W  port-B address.
- `ceb`  out  1  port-B clock enable; high only in read-issue cycles.
- `oceb`  out  1  port-B output-register enable; constant 1.
- `wreb`  out  1  constant 0.
- `resetb`  out  1  constant 0.
- `dinb`  out  DATA_W  constant 0.
- `doutb`  in  DATA_W  port-B read data.
- `m_data`  out  DATA_W  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: on `start`=1, capture `base_addr` and `length`.
  - If `length`=0, go to IDLE with a `done` pulse the next cycle. No reads are issued.
  - Otherwise go to RUN.
- RUN issues one read per cycle (`ceb`=1, `adb`=current address) when both hold:
  - `issue_left` > 0;
  - `inflight + fifo_count < 4`. `inflight` counts issued reads whose data has not yet been written to the FIFO. A pop in the same cycle does not free a credit until the next cycle.
- After each issue, the address increments, wrapping from 2^ADDR_W−1 to 0.
- When the last read is issued, go to DRAIN.
- Read tracking: a RD_LAT-deep valid shift register follows each issue. When it exits, `doutb` is written into the FIFO.
- DRAIN: when the final beat handshakes (`m_valid` & `m_ready`), pulse `done`, drop `busy`, and return to IDLE.
- `start` while busy is ignored.
- `m_data`/`m_valid` come from the FIFO head (registered outputs). `m_data` is stable while `m_valid` & !`m_ready`. Data order equals address order.
- Width rules:
  - `length` is ADDR_W+1 bits, so a full 2^ADDR_W transfer is legal.
  - Internal beat counters are ADDR_W+1 bits.
  - The address is ADDR_W bits and wraps silently.
- Reset (`rst_n`=0, at any time, including mid-transfer):
  - state returns to IDLE; FIFO and in-flight tracking are cleared;
  - outputs `busy`, `done`, `m_valid`, `ceb` = 0; `adb`, `m_data` = 0; `oceb`=1; `wreb`, `resetb`, `dinb` = 0;
  - in-flight RAM data is discarded.

## Timing
- Latency: `start` sampled at edge E0. The first `ceb`=1 occurs in the cycle after E0, with `adb`=`base_addr`. The first `m_valid`=1 occurs RD_LAT+2 cycles after E0.
- `busy` rises in the cycle after E0.
- Throughput: one beat per cycle sustained while `m_ready`=1, for both RD_LAT values.
- Backpressure: with `m_ready`=0, at most 4 reads are outstanding plus buffered. Issue stalls and resumes the cycle after credit frees.
- `done` is asserted in the cycle after the last handshake edge. `busy` falls in the same cycle.
- Back-to-back commands: a `start` in the `done` cycle is accepted.

## Configuration
- `DPB_STREAM_LAST_EN`
  - Defined: adds output port `m_last` (1 bit). It is high with the final beat of each command and qualified by `m_valid`. It is 0 at reset.
  - Undefined: no `m_last` port; all other behaviour is identical.

## Test plan
- Preload RAM[i]=i[7:0]; base=0x0010, length=5, `m_ready`=1 → beats 0x10..0x14. First `m_valid` at E0+4 with RD_LAT=2. One `done` pulse, asserted one cycle after beat 0x14; `m_last` on 0x14 when enabled.
- base=0x3FFE, length=4 → `adb` sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001; data order matches.
- length=20, `m_ready` toggling 1-0-0-1 → all 20 beats in order, no loss or duplication; at most 4 reads outstanding plus buffered, checked every cycle.
- length=0 → no `ceb` pulse, `m_valid` stays 0, `done` asserted one cycle after E0.
- `rst_n` low for 2 cycles mid-transfer (beat 3 of 10) → all outputs at reset values; a new start with base=0x0100, length=2 then yields exactly RAM[0x100], RAM[0x101].
- `start` pulsed while busy → ignored: beat count and data are unchanged.

Source files
------------

// File: rtl/dpb_stream_reader.sv
// Port-B read engine for the Gowin DPB: streams `length` bytes from `base_addr` with a credit-limited prefetch FIFO.
// Optional `DPB_STREAM_LAST_EN` adds an m_last output marking the final beat of each command.
module dpb_stream_reader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] adb,
  output logic              ceb,
  output logic              oceb,
  output logic              wreb,
  output logic              resetb,
  output logic [DATA_W-1:0] dinb,
  input  logic [DATA_W-1:0] doutb,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
`ifdef DPB_STREAM_LAST_EN
  ,
  output logic              m_last
`endif
);

  // state  | meaning
  // IDLE   | waiting for start; length 0 completes immediately
  // RUN    | issuing reads while credits and issue_left allow
  // DRAIN  | all reads issued; waiting for the final beat to handshake
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 4;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     issue_left_q;
  logic [ADDR_W:0]     beats_left_q;
  logic                done_q, done_d;
  logic                accept;
  logic [RD_LAT-1:0]   rd_pipe_q;
  logic [2:0]          inflight_q;
  logic [2:0]          fifo_cnt_q;
  logic [1:0]          wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];

  logic                credit_ok;
  logic                issue;
  logic                push;
  logic                pop;
  logic                last_beat;

  // Credits use registered counts only, so a pop frees its slot one cycle later.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < 4'd4;
  assign issue     = (state_q == S_RUN) && (issue_left_q != '0) && credit_ok;
  assign push      = rd_pipe_q[RD_LAT-1];
  assign m_valid   = (fifo_cnt_q != 3'd0);
  assign pop       = m_valid && m_ready;
  assign last_beat = pop && (beats_left_q == (ADDR_W+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (issue && (issue_left_q == (ADDR_W+1)'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_beat) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      issue_left_q <= '0;
      beats_left_q <= '0;
    end else if (accept) begin
      addr_q       <= base_addr;
      issue_left_q <= length;
      beats_left_q <= length;
    end else begin
      if (issue) begin
        addr_q       <= addr_q + ADDR_W'(1);
        issue_left_q <= issue_left_q - (ADDR_W+1)'(1);
      end
      if (pop) begin
        beats_left_q <= beats_left_q - (ADDR_W+1)'(1);
      end
    end
  end

  // Each issue rides this pipe; its exit marks doutb as valid for that read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe_q <= '0;
    end else begin
      rd_pipe_q[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 3'd0;
    end else begin
      case ({issue, push})
        2'b10:   inflight_q <= inflight_q + 3'd1;
        2'b01:   inflight_q <= inflight_q - 3'd1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      fifo_cnt_q <= 3'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= doutb;
        wr_ptr_q             <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign adb    = addr_q;
  assign ceb    = issue;
  assign oceb   = 1'b1;
  assign wreb   = 1'b0;
  assign resetb = 1'b0;
  assign dinb   = '0;
  assign m_data = fifo_mem_q[rd_ptr_q];

`ifdef DPB_STREAM_LAST_EN
  assign m_last = m_valid && (beats_left_q == (ADDR_W+1)'(1));
`endif

endmodule

// File: tb/tb_dpb_stream_reader.sv
// Scoreboard bench for dpb_stream_reader with a behavioural RD_LAT=2 port-B RAM model.
module tb_dpb_stream_reader;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int MEM_N  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy, done, ceb, oceb, wreb, resetb, m_valid, m_ready;
  logic [ADDR_W-1:0] adb;
  logic [DATA_W-1:0] dinb, doutb, m_data;
`ifdef DPB_STREAM_LAST_EN
  logic              m_last;
`endif

  dpb_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .adb       (adb),
    .ceb       (ceb),
    .oceb      (oceb),
    .wreb      (wreb),
    .resetb    (resetb),
    .dinb      (dinb),
    .doutb     (doutb),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
`ifdef DPB_STREAM_LAST_EN
    ,
    .m_last    (m_last)
`endif
  );

  logic [DATA_W-1:0] mem [MEM_N];
  logic [DATA_W-1:0] ram_q;

  // Port B: array read on ceb, then the always-enabled output register.
  always @(posedge clk) begin
    if (ceb) ram_q <= mem[adb];
    doutb <= ram_q;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic              exp_last_q[$];
  logic [ADDR_W-1:0] adb_log[$];

  int e0, first_ceb, first_busy, first_valid, last_hs, done_cyc;
  int done_cnt, beats, ceb_cnt, outstanding;
  logic [ADDR_W-1:0] first_ceb_adb;
  logic              busy_at_done;
  logic              prev_stall;
  logic [DATA_W-1:0] prev_data;
  int                ready_mode = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // m_ready changes just after each rising edge; pattern 1-0-0-1 in mode 1.
  initial begin
    int phase = 0;
    logic [3:0] pat = 4'b1001;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        m_ready = 1'b1;
        phase = 0;
      end else begin
        m_ready = pat[3 - phase];
        phase = (phase + 1) % 4;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (ceb) begin
        ceb_cnt++;
        outstanding++;
        adb_log.push_back(adb);
        if (first_ceb < 0) begin
          first_ceb = cyc;
          first_ceb_adb = adb;
        end
      end
      if (busy && first_busy < 0) first_busy = cyc;
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall) check_val("stall_data_stable", {m_valid, m_data}, {1'b1, prev_data});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_beat", 1, 0);
        end else begin
          check_val("beat_data", m_data, exp_q.pop_front());
`ifdef DPB_STREAM_LAST_EN
          check_val("beat_last", m_last, exp_last_q.pop_front());
`else
          void'(exp_last_q.pop_front());
`endif
        end
        beats++;
        last_hs = cyc;
        outstanding--;
      end
      if (busy) check_val("credit_limit", outstanding <= 4, 1);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          busy_at_done = busy;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_stats();
    first_ceb = -1; first_busy = -1; first_valid = -1; last_hs = -1; done_cyc = -1;
    done_cnt = 0; beats = 0; ceb_cnt = 0;
    adb_log.delete();
  endtask

  task automatic start_cmd(input logic [ADDR_W-1:0] b, input int len);
    @(posedge clk);
    #1;
    clear_stats();
    start = 1'b1;
    base_addr = b;
    length = (ADDR_W+1)'(len);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(mem[(int'(b) + i) % MEM_N]);
      exp_last_q.push_back(i == len - 1);
    end
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && done_cyc < 0; i++) @(posedge clk);
    if (done_cyc < 0) check_val({tag, "_done_timeout"}, 0, 1);
    repeat (4) @(posedge clk);
    check_val({tag, "_done_count"}, done_cnt, 1);
    check_val({tag, "_busy_low_at_done"}, busy_at_done, 0);
    check_val({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_m_valid"}, m_valid, 0);
    check_val({tag, "_ceb"}, ceb, 0);
    check_val({tag, "_adb"}, adb, 0);
    check_val({tag, "_m_data"}, m_data, 0);
    check_val({tag, "_consts"}, {oceb, wreb, resetb, dinb}, {1'b1, 1'b0, 1'b0, 8'h00});
`ifdef DPB_STREAM_LAST_EN
    check_val({tag, "_m_last"}, m_last, 0);
`endif
  endtask

  initial begin
    for (int i = 0; i < MEM_N; i++) mem[i] = i[7:0];
    start = 1'b0; base_addr = '0; length = '0;
    outstanding = 0; prev_stall = 1'b0; busy_at_done = 1'b0;
    clear_stats();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // basic 5-beat read with full-rate ready
    start_cmd(14'h0010, 5);
    wait_done("basic");
    check_val("basic_first_ceb_cycle", first_ceb - e0, 0);
    check_val("basic_first_ceb_adb", first_ceb_adb, 14'h0010);
    check_val("basic_busy_rise", first_busy - e0, 0);
    check_val("basic_first_valid", first_valid - e0, RD_LAT + 1);
    check_val("basic_done_after_last", done_cyc - last_hs, 1);
    check_val("basic_beats", beats, 5);
    check_val("basic_throughput", last_hs - first_valid, 4);

    // address wrap at the top of the RAM
    start_cmd(14'h3FFE, 4);
    wait_done("wrap");
    check_val("wrap_issue_count", adb_log.size(), 4);
    for (int i = 0; i < 4 && i < adb_log.size(); i++)
      check_val("wrap_adb", adb_log[i], (14'h3FFE + 14'(i)) & 14'h3FFF);
    check_val("wrap_beats", beats, 4);

    // backpressure 1-0-0-1
    ready_mode = 1;
    start_cmd(14'h0200, 20);
    wait_done("bp");
    ready_mode = 0;
    check_val("bp_beats", beats, 20);
    check_val("bp_issues", ceb_cnt, 20);

    // zero length
    start_cmd(14'h0040, 0);
    wait_done("zero");
    check_val("zero_ceb_count", ceb_cnt, 0);
    check_val("zero_no_valid", first_valid, -1);
    check_val("zero_done_cycle", done_cyc - e0, 0);

    // reset in the middle of a 10-beat transfer
    start_cmd(14'h0000, 10);
    for (int i = 0; i < 200 && beats < 3; i++) @(posedge clk);
    check_val("midrst_reached_beat3", beats >= 3, 1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
    outstanding = 0;
    @(negedge clk);
    check_reset_outputs("midrst_a");
    @(negedge clk);
    check_reset_outputs("midrst_b");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    start_cmd(14'h0100, 2);
    wait_done("postrst");
    check_val("postrst_beats", beats, 2);

    // start pulsed while busy must be ignored
    start_cmd(14'h0020, 6);
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = 14'h0300; length = 15'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ignore");
    repeat (20) @(posedge clk);
    check_val("ignore_beats", beats, 6);
    check_val("ignore_issues", ceb_cnt, 6);
    check_val("ignore_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
